// File: rtl/arcade_io_pkg.sv
// arcade_io_pkg: shared types and helpers for the arcade input front end
//   DIP_INDEX_DEFAULT : ioctl index that carries DIP switch data
//   coin_state_t      : per-channel coin pulse FSM states
//   active_low()      : converts an active-high level to an active-low pin level
package arcade_io_pkg;
    localparam logic [7:0] DIP_INDEX_DEFAULT = 8'hFE;
    typedef enum logic [1:0] {CN_IDLE, CN_PULSE, CN_GAP} coin_state_t;
    function automatic logic active_low(input logic v);
        return ~v;
    endfunction
endpackage

// File: rtl/coin_shaper.sv
// coin_shaper: one coin channel - press edge detect, saturating press queue, frame-timed pulse FSM
//   i_clk, i_reset_n : clock, async active-low reset
//   i_tick           : one-cycle frame tick
//   i_coin           : raw coin button, active-high
//   o_coin_n         : shaped coin pulse, active-low
module coin_shaper
    import arcade_io_pkg::*;
#(
    parameter int COIN_FRAMES = 2,
    parameter int COIN_QUEUE  = 3
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_tick,
    input  logic i_coin,
    output logic o_coin_n
);
    coin_state_t r_state, w_state_nx;
    logic       r_coin_q;
    logic [2:0] r_pending, w_pending_nx;
    logic [3:0] r_frames, w_frames_nx;
    logic       w_rise, w_start;

    assign w_rise  = i_coin & ~r_coin_q;
    // GAP may start the next pulse on its tick; the tick that ends a pulse cannot, giving one idle frame
    assign w_start = i_tick && r_state != CN_PULSE && r_pending != 3'd0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= CN_IDLE;
            r_coin_q  <= 1'b0;
            r_pending <= 3'd0;
            r_frames  <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_coin_q  <= i_coin;
            r_pending <= w_pending_nx;
            r_frames  <= w_frames_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_frames_nx  = r_frames;
        w_pending_nx = r_pending;
        // a press landing on a pulse-start cycle cancels the dequeue
        if (w_rise && !w_start && r_pending != 3'(COIN_QUEUE))
            w_pending_nx = r_pending + 3'd1;
        else if (!w_rise && w_start)
            w_pending_nx = r_pending - 3'd1;
        if (w_start) begin
            w_state_nx  = CN_PULSE;
            w_frames_nx = 4'(COIN_FRAMES);
        end else if (i_tick && r_state == CN_PULSE) begin
            w_frames_nx = r_frames - 4'd1;
            w_state_nx  = (r_frames == 4'd1) ? CN_GAP : CN_PULSE;
        end else if (i_tick && r_state == CN_GAP) begin
            w_state_nx = CN_IDLE;
        end
    end

    assign o_coin_n = active_low(r_state == CN_PULSE);
endmodule

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: frame-synced controls, shaped coins, ioctl-loaded DIPs and stretched core reset
//   i_clk_sys, i_reset_n       : system clock, async active-low reset
//   i_vblank                   : core vblank, rising edge is the frame tick
//   i_btn / i_coin             : raw active-high controls and coin buttons
//   i_ioctl_*                  : download bus (download, wr strobe, index, addr, data)
//   o_ctrl_n / o_coin_n        : active-low frame-sampled controls and coin pulses
//   o_dip                      : committed DIP bytes
//   o_core_reset               : active-high core reset
module arcade_input_ctrl
    import arcade_io_pkg::*;
#(
    parameter int         PLAYERS     = 2,
    parameter int         BUTTONS     = 4,
    parameter int         COINS       = 1,
    parameter int         COIN_FRAMES = 2,
    parameter int         COIN_QUEUE  = 3,
    parameter int         DIP_BYTES   = 1,
    parameter logic [7:0] DIP_INDEX   = DIP_INDEX_DEFAULT,
    parameter logic [7:0] DIP_DEFAULT = 8'h00,
    parameter int         RESET_HOLD  = 16
) (
    input  logic                         i_clk_sys,
    input  logic                         i_reset_n,
    input  logic                         i_vblank,
    input  logic [PLAYERS*BUTTONS-1:0]   i_btn,
    input  logic [COINS-1:0]             i_coin,
    input  logic                         i_ioctl_download,
    input  logic                         i_ioctl_wr,
    input  logic [7:0]                   i_ioctl_index,
    input  logic [24:0]                  i_ioctl_addr,
    input  logic [7:0]                   i_ioctl_dout,
    output logic [PLAYERS*BUTTONS-1:0]   o_ctrl_n,
    output logic [COINS-1:0]             o_coin_n,
    output logic [8*DIP_BYTES-1:0]       o_dip,
    output logic                         o_core_reset
);
    localparam int HW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

    logic                       r_vblank_q;
    logic [PLAYERS*BUTTONS-1:0] r_ctrl_n;
    logic [8*DIP_BYTES-1:0]     r_shadow, r_dip;
    logic                       r_dip_wr;
    logic                       r_dl_q;
    logic [HW-1:0]              r_hold;
    logic                       r_core_reset;
    logic                       w_tick, w_dip_wr, w_dl_fall, w_rom;

    assign w_tick    = i_vblank & ~r_vblank_q;
    assign w_dip_wr  = i_ioctl_wr && i_ioctl_download && i_ioctl_index == DIP_INDEX
                       && i_ioctl_addr < 25'(DIP_BYTES);
    assign w_dl_fall = r_dl_q & ~i_ioctl_download;
    assign w_rom     = i_ioctl_download && i_ioctl_index != DIP_INDEX;

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vblank_q   <= 1'b0;
            r_ctrl_n     <= '1;
            r_shadow     <= {DIP_BYTES{DIP_DEFAULT}};
            r_dip        <= {DIP_BYTES{DIP_DEFAULT}};
            r_dip_wr     <= 1'b0;
            r_dl_q       <= 1'b0;
            r_hold       <= HW'(RESET_HOLD);
            r_core_reset <= 1'b1;
        end else begin
            r_vblank_q <= i_vblank;
            if (w_tick)
                r_ctrl_n <= ~i_btn;
            for (int b = 0; b < DIP_BYTES; b++)
                if (w_dip_wr && i_ioctl_addr == 25'(b))
                    r_shadow[b*8 +: 8] <= i_ioctl_dout;
            r_dl_q <= i_ioctl_download;
            // commit only if this download actually delivered DIP data
            if (w_dl_fall) begin
                r_dip_wr <= 1'b0;
                if (r_dip_wr)
                    r_dip <= r_shadow;
            end else if (w_dip_wr) begin
                r_dip_wr <= 1'b1;
            end
            // counter reloads while a ROM download runs; reset drops on the cycle it reaches zero
            r_hold       <= w_rom ? HW'(RESET_HOLD) : r_hold - HW'(r_hold != '0);
            r_core_reset <= w_rom || r_hold > HW'(1);
        end
    end

    for (genvar c = 0; c < COINS; c++) begin : g_coin
        coin_shaper #(
            .COIN_FRAMES(COIN_FRAMES),
            .COIN_QUEUE (COIN_QUEUE)
        ) u_coin (
            .i_clk    (i_clk_sys),
            .i_reset_n(i_reset_n),
            .i_tick   (w_tick),
            .i_coin   (i_coin[c]),
            .o_coin_n (o_coin_n[c])
        );
    end

    assign o_ctrl_n     = r_ctrl_n;
    assign o_dip        = r_dip;
    assign o_core_reset = r_core_reset;
endmodule
